// File: rtl/fir_th_pipe.sv
// Programmable-coefficient FIR filter with a registered threshold compare on its output.
// Define FIR_HYST_EN to put a hysteresis band of HYST below thresh on the compare result y.
module fir_th_pipe #(
    parameter int NTAPS = 9,
    parameter int XW    = 4,
    parameter int CW    = 4,
    parameter int HYST  = 2,
    localparam int AW   = $clog2(NTAPS),
    localparam int ACCW = XW + CW + $clog2(NTAPS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            coef_we,
    input  logic [AW-1:0]   coef_addr,
    input  logic [CW-1:0]   coef_wdata,
    input  logic            in_valid,
    input  logic [XW-1:0]   x,
    input  logic [ACCW-1:0] thresh,
    output logic            out_valid,
    output logic [ACCW-1:0] acc,
    output logic            y
);
    localparam int PW = XW + CW;

    if (NTAPS < 2 || NTAPS > 32 || HYST < 0) begin : g_bad_param
        $error("fir_th_pipe: NTAPS must be 2..32 and HYST non-negative");
    end

    logic [XW-1:0]   tap_q  [NTAPS];
    logic [XW-1:0]   tap_d  [NTAPS];
    logic [CW-1:0]   coef_q [NTAPS];
    logic [CW-1:0]   coef_d [NTAPS];
    logic [PW-1:0]   p_q    [NTAPS];
    logic [PW-1:0]   p_d    [NTAPS];
    logic [ACCW-1:0] sum_q, sum_d;
    logic [ACCW-1:0] th0_q, th0_d, th1_q, th1_d, th2_q, th2_d;
    logic            v0_q, v0_d, v1_q, v1_d, v2_q, v2_d;
    logic [ACCW-1:0] acc_q, acc_d;
    logic            y_q, y_d;
    logic            out_valid_q, out_valid_d;
    logic            y_new;

    // Taps and coefficients; a write landing on the same edge as a sample is seen by it.
    always_comb begin
        tap_d  = tap_q;
        coef_d = coef_q;
        if (in_valid) begin
            tap_d[0] = x;
            for (int i = 1; i < NTAPS; i++) begin
                tap_d[i] = tap_q[i-1];
            end
        end
        for (int i = 0; i < NTAPS; i++) begin
            if (coef_we && coef_addr == AW'(i)) begin
                coef_d[i] = coef_wdata;
            end
        end
    end

    // Product, sum and output stages advance every cycle; the valid tag gates the output.
    always_comb begin
        for (int i = 0; i < NTAPS; i++) begin
            p_d[i] = PW'(coef_q[i]) * PW'(tap_q[i]);
        end
        sum_d = '0;
        for (int i = 0; i < NTAPS; i++) begin
            sum_d = sum_d + ACCW'(p_q[i]);
        end
        v0_d  = in_valid;
        th0_d = thresh;
        v1_d  = v0_q;
        th1_d = th0_q;
        v2_d  = v1_q;
        th2_d = th1_q;
    end

`ifdef FIR_HYST_EN
    localparam logic [ACCW-1:0] HYST_W = ACCW'(HYST);
    logic [ACCW-1:0] th_lo;

    always_comb begin
        th_lo = (th2_q > HYST_W) ? th2_q - HYST_W : '0;
        y_new = y_q;
        if (sum_q > th2_q) begin
            y_new = 1'b1;
        end else if (sum_q < th_lo) begin
            y_new = 1'b0;
        end
    end
`else
    always_comb begin
        y_new = sum_q > th2_q;
    end
`endif

    always_comb begin
        acc_d       = acc_q;
        y_d         = y_q;
        out_valid_d = v2_q;
        if (v2_q) begin
            acc_d = sum_q;
            y_d   = y_new;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap_q       <= '{default: '0};
            coef_q      <= '{default: '0};
            p_q         <= '{default: '0};
            sum_q       <= '0;
            th0_q       <= '0;
            th1_q       <= '0;
            th2_q       <= '0;
            v0_q        <= 1'b0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            acc_q       <= '0;
            y_q         <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            tap_q       <= tap_d;
            coef_q      <= coef_d;
            p_q         <= p_d;
            sum_q       <= sum_d;
            th0_q       <= th0_d;
            th1_q       <= th1_d;
            th2_q       <= th2_d;
            v0_q        <= v0_d;
            v1_q        <= v1_d;
            v2_q        <= v2_d;
            acc_q       <= acc_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign acc       = acc_q;
    assign y         = y_q;

endmodule

// File: tb/tb_fir_th_pipe.sv
// Directed bench for fir_th_pipe (default build, hysteresis off): impulse, threshold edge,
// gapped input, full-scale sum and mid-stream reset, checked by a timestamped scoreboard.
module tb_fir_th_pipe;
    localparam int NTAPS = 9;
    localparam int XW    = 4;
    localparam int CW    = 4;
    localparam int AW    = 4;
    localparam int ACCW  = 12;

    logic            clk;
    logic            rst;
    logic            coef_we;
    logic [AW-1:0]   coef_addr;
    logic [CW-1:0]   coef_wdata;
    logic            in_valid;
    logic [XW-1:0]   x;
    logic [ACCW-1:0] thresh;
    logic            out_valid;
    logic [ACCW-1:0] acc;
    logic            y;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [ACCW-1:0] exp_q[$];
    logic            exp_y_q[$];
    int              exp_c_q[$];
    logic [ACCW-1:0] last_acc = '0;
    logic            last_y   = 1'b0;

    fir_th_pipe #(.NTAPS(NTAPS), .XW(XW), .CW(CW), .HYST(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .in_valid   (in_valid),
        .x          (x),
        .thresh     (thresh),
        .out_valid  (out_valid),
        .acc        (acc),
        .y          (y)
    );

    // Clock and cycle stamp
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Driver tasks: inputs change on the falling edge, the DUT takes them on the next rising edge
    task automatic step(input logic we, input int a, input int d, input logic v, input int xv,
                        input int th, input int eacc, input logic ey);
        @(negedge clk);
        coef_we    = we;
        coef_addr  = AW'(a);
        coef_wdata = CW'(d);
        in_valid   = v;
        x          = XW'(xv);
        thresh     = ACCW'(th);
        if (v) begin
            exp_q.push_back(ACCW'(eacc));
            exp_y_q.push_back(ey);
            exp_c_q.push_back(cyc + 4);
        end
    endtask

    task automatic wr(input int a, input int d);
        step(1'b1, a, d, 1'b0, 0, 0, 0, 1'b0);
    endtask

    task automatic smp(input int xv, input int th, input int eacc, input logic ey);
        step(1'b0, 0, 0, 1'b1, xv, th, eacc, ey);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 0, 0, 1'b0, int'($urandom_range(0, 15)), int'($urandom_range(0, 40)), 0, 1'b0);
        end
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        #2;
        rst      = 1'b1;
        in_valid = 1'b0;
        coef_we  = 1'b0;
        exp_q.delete();
        exp_y_q.delete();
        exp_c_q.delete();
        last_acc = '0;
        last_y   = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_acc", 32'(acc), 0);
        check("rst_y", 32'(y), 0);
        @(negedge clk);
        #2;
        rst = 1'b0;
    endtask

    // Scoreboard: every out_valid must match the oldest expected result at its expected cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 32'(1), 0);
                end else begin
                    last_acc = exp_q.pop_front();
                    last_y   = exp_y_q.pop_front();
                    check("acc", 32'(acc), 32'(last_acc));
                    check("y", 32'(y), 32'(last_y));
                    check("latency", 32'(cyc), 32'(exp_c_q.pop_front()));
                end
            end else begin
                check("hold_acc", 32'(acc), 32'(last_acc));
                check("hold_y", 32'(y), 32'(last_y));
            end
        end
    end

    initial begin
        rst        = 1'b1;
        coef_we    = 1'b0;
        coef_addr  = '0;
        coef_wdata = '0;
        in_valid   = 1'b0;
        x          = '0;
        thresh     = '0;
        repeat (2) @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_acc", 32'(acc), 0);
        check("reset_y", 32'(y), 0);
        #2;
        rst = 1'b0;

        // Impulse through coef = 1..9; out-of-range writes must not alias onto real taps
        for (int i = 0; i < NTAPS; i++) wr(i, i + 1);
        for (int a = NTAPS; a < 16; a++) wr(a, 0);
        for (int i = 0; i < NTAPS; i++) smp((i == 0) ? 1 : 0, 5, i + 1, (i + 1) > 5);
        idle(5);

        // Threshold edge, with a coef write on the same edge as the first sample
        for (int i = 1; i < NTAPS; i++) wr(i, 0);
        step(1'b1, 0, 2, 1'b1, 10, 20, 20, 1'b0);
        smp(10, 19, 20, 1'b1);
        smp(10, 21, 20, 1'b0);
        smp(11, 21, 22, 1'b1);
        idle(4);

        // Gapped input: taps hold across idle cycles even while x toggles
        wr(1, 1);
        smp(3, 15, 17, 1'b1);
        idle(2);
        smp(5, 15, 13, 1'b0);
        idle(4);

        // Full-scale: all coef 15, nine samples of 15
        rst_pulse();
        for (int i = 0; i < NTAPS; i++) wr(i, 15);
        for (int n = 1; n <= NTAPS; n++) smp(15, 2024, 225 * n, n == NTAPS);
        idle(5);

        // Mid-stream reset discards in-flight samples and clears coef and taps
        for (int n = 0; n < 3; n++) smp(1, 0, 0, 1'b0);
        rst_pulse();
        idle(6);
        wr(8, 1);
        smp(2, 0, 0, 1'b0);
        idle(5);

        check("drain", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
